// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART path: oversampling-ratio encodings, the
// default divisor widths and reset divisor, the baud configuration record used
// by the CSR block, and a helper that maps the OSR select onto the last phase
// index.
//
// Contents:
//   DIV_W_DEF / FRAC_W_DEF : default integer / fractional divisor widths
//   DIV_RST_DEF            : integer divisor after reset (27 MHz, 115200, 16x)
//   OSR16 / OSR8           : osr_sel encodings
//   baud_cfg_t             : {div_int, div_frac, osr} at the default widths
//   osr_last()             : OSR-1 for a given osr_sel value
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DIV_W_DEF   = 16;
    localparam int FRAC_W_DEF  = 4;
    localparam int DIV_RST_DEF = 15;

    localparam logic OSR16 = 1'b0;
    localparam logic OSR8  = 1'b1;

    // Configuration record as seen by the CSR block. Modules with non-default
    // widths declare a parameterised copy with the same field order.
    typedef struct packed {
        logic [DIV_W_DEF-1:0]  div_int;
        logic [FRAC_W_DEF-1:0] div_frac;
        logic                  osr;
    } baud_cfg_t;

    // Highest phase index for the selected oversampling ratio.
    function automatic logic [3:0] osr_last(input logic osr);
        return (osr == OSR8) ? 4'd7 : 4'd15;
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// -----------------------------------------------------------------------------
// baud_frac_acc
//
// Fractional phase accumulator for the baud generator. Each oversample
// interval adds the fractional divisor to the accumulator; a carry out
// stretches that interval by one clock so the long-run average period is
// exactly int + frac/2^FRAC_W.
//
// The accumulator holds the value from before the current interval; its sum
// with the fraction decides the current interval length and is committed when
// the interval ends.
//
// Only built when BAUD_GEN_FRAC_EN is defined.
//
// Ports:
//   clk      in            system clock
//   rst      in            asynchronous active-high reset
//   i_clear  in            synchronous clear of the accumulator
//   i_adv    in            current interval ends this cycle, commit the sum
//   i_int    in  [DIV_W]   active integer divisor
//   i_frac   in  [FRAC_W]  active fractional divisor
//   o_last   out [DIV_W]   terminal count of the current interval (P-1)
// -----------------------------------------------------------------------------
`ifdef BAUD_GEN_FRAC_EN
module baud_frac_acc
    import uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_adv,
    input  logic [DIV_W-1:0]  i_int,
    input  logic [FRAC_W-1:0] i_frac,
    output logic [DIV_W-1:0]  o_last
);

    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, i_frac};

    // P-1 = int - 1 + carry; the caller ignores this when int is zero.
    assign o_last = i_int - DIV_W'(1) + DIV_W'(w_sum[FRAC_W]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_adv) begin
            r_acc <= w_sum[FRAC_W-1:0];
        end
    end

endmodule
`endif

// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
//
// Fractional-divisor oversampling baud tick generator. Produces a one-cycle
// oversample tick (16x or 8x the bit rate) and a one-cycle bit_tick on the
// last oversample of each bit. The divisor is int + frac/2^FRAC_W clocks per
// oversample tick.
//
// New settings are written to a shadow register by cfg_load and moved into
// the active configuration only at a safe point: at the end of the current
// interval, immediately while disabled, or immediately when the active integer
// divisor is zero (generator stalled). cfg_ack pulses the cycle after the
// move.
//
// phase counts ticks modulo OSR and updates together with tick, so the tick
// that carries bit_tick shows phase 0.
//
// Build option:
//   BAUD_GEN_FRAC_EN  defined   : fractional accumulator present
//                     undefined : div_frac ignored, interval = div_int exactly
//
// Ports:
//   clk          in            system clock
//   rst          in            asynchronous active-high reset
//   en           in            generator enable
//   div_int      in  [DIV_W]   requested integer divisor
//   div_frac     in  [FRAC_W]  requested fractional divisor
//   osr_sel      in            0 = 16x, 1 = 8x oversampling
//   cfg_load     in            strobe: capture div_int/div_frac/osr_sel
//   cfg_pending  out           shadow holds an unapplied configuration
//   cfg_ack      out           pulse: new configuration became active
//   tick         out           oversample tick
//   bit_tick     out           bit-period tick
//   phase        out [4]       oversample phase index
// -----------------------------------------------------------------------------
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              osr_sel,
    input  logic              cfg_load,
    output logic              cfg_pending,
    output logic              cfg_ack,
    output logic              tick,
    output logic              bit_tick,
    output logic [3:0]        phase
);

    // Width-parameterised form of uart_pkg::baud_cfg_t.
    typedef struct packed {
        logic [DIV_W-1:0]  div_int;
        logic [FRAC_W-1:0] div_frac;
        logic              osr;
    } cfg_t;

    localparam cfg_t CFG_RST = '{DIV_W'(DIV_RST), {FRAC_W{1'b0}}, OSR16};

    cfg_t             r_active;
    cfg_t             r_shadow;
    logic             r_pending;
    logic             r_ack;
    logic [DIV_W-1:0] r_cnt;
    logic [3:0]       r_phase;
    logic             r_tick;
    logic             r_bit_tick;

    cfg_t             w_cfg_in;
    logic [DIV_W-1:0] w_last;
    logic             w_valid;
    logic             w_end;
    logic             w_apply;
    logic             w_clear;
    logic [3:0]       w_osr_last;

`ifdef BAUD_GEN_FRAC_EN
    assign w_cfg_in = '{div_int, div_frac, osr_sel};

    baud_frac_acc #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_adv   (w_end),
        .i_int   (r_active.div_int),
        .i_frac  (r_active.div_frac),
        .o_last  (w_last)
    );
`else
    // Fraction is dropped at capture so its flops reduce to constants.
    assign w_cfg_in = '{div_int, {FRAC_W{1'b0}}, osr_sel};
    assign w_last   = r_active.div_int - DIV_W'(1);

    logic w_unused;
    assign w_unused = ^{div_frac, r_active.div_frac};
`endif

    // A zero integer divisor stalls the generator rather than wrapping w_last.
    assign w_valid    = |r_active.div_int;
    assign w_end      = en & w_valid & (r_cnt == w_last);
    assign w_osr_last = osr_last(r_active.osr);

    // Safe points for swapping in the shadow: disabled, stalled, or the
    // current interval is ending (its tick still goes out next cycle).
    assign w_apply = r_pending & (~en | ~w_valid | w_end);
    assign w_clear = ~en | ~w_valid | w_apply;

    // Shadow capture, pending flag and active configuration. A load in the
    // same cycle as an apply refills the shadow and keeps pending set, while
    // the apply itself takes the previous shadow contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active  <= CFG_RST;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= w_apply;
            if (w_apply) begin
                r_active <= r_shadow;
            end
            if (cfg_load) begin
                r_shadow  <= w_cfg_in;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Interval counter: runs 0..P-1, restarts at the end of each interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_clear || w_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    // Tick, bit tick and phase are registered off the interval end. On an
    // apply the phase restarts but the tick of the finished interval stays.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick     <= 1'b0;
            r_bit_tick <= 1'b0;
            r_phase    <= '0;
        end else begin
            r_tick     <= w_end;
            r_bit_tick <= w_end & (r_phase == w_osr_last);
            if (w_clear) begin
                r_phase <= '0;
            end else if (w_end) begin
                r_phase <= (r_phase == w_osr_last) ? 4'd0 : r_phase + 4'd1;
            end
        end
    end

    assign cfg_pending = r_pending;
    assign cfg_ack     = r_ack;
    assign tick        = r_tick;
    assign bit_tick    = r_bit_tick;
    assign phase       = r_phase;

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised, fractional-divisor oversampling baud tick generator for the UART path. It generates a 1-cycle oversample `tick` (16x or 8x the bit rate) and a 1-cycle `bit_tick` per bit period. The divisor is fixed-point (integer plus fraction), so non-integer clock/baud ratios average out exactly. Runtime reconfiguration goes through a shadow register and is applied glitch-free on a tick boundary. The UART TX/RX engines consume `tick`/`bit_tick`; the CSR block drives the config inputs.

## Interface
Parameters:
- `DIV_W`, 16: integer divisor width.
- `FRAC_W`, 4: fractional divisor width; fraction = `div_frac`/2^FRAC_W.
- `DIV_RST`, 15: active integer divisor after reset (27 MHz, 115200 baud, 16x → 14.65).

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: generator enable.
- `div_int` in DIV_W: requested integer divisor, in clk cycles per oversample tick.
- `div_frac` in FRAC_W: requested fractional divisor.
- `osr_sel` in 1: 0 = 16x oversampling, 1 = 8x.
- `cfg_load` in 1: 1-cycle strobe; captures `div_int`/`div_frac`/`osr_sel` into the shadow register.
- `cfg_pending` out 1: shadow holds a configuration not yet applied.
- `cfg_ack` out 1: 1-cycle pulse in the cycle the new configuration becomes active.
- `tick` out 1: oversample tick, 1 cycle wide.
- `bit_tick` out 1: bit-period tick, coincident with the last `tick` of each bit.
- `phase` out 4: oversample phase index, 0..OSR-1.

## Operation
- Active config = {`a_int`, `a_frac`, `a_osr`}. Reset value: {DIV_RST, 0, 16x}.
- OSR = 16 when `a_osr`=0, else 8.
- Interval start: `acc_sum` = `acc` + `a_frac` (FRAC_W+1 bits). Interval length P = `a_int` + `acc_sum`[FRAC_W]. `acc` ← `acc_sum`[FRAC_W-1:0].
- `cnt` counts 0..P-1. At `cnt`=P-1:
  - `cnt` ← 0 and the next interval starts.
  - `tick` is registered high in the following cycle.
- `phase` increments on each `tick` and wraps at OSR-1 → 0.
- `bit_tick` is high in the same cycle as the `tick` that moves `phase` from OSR-1 to 0.
- `a_int`=0 is invalid: `cnt`, `acc` and `phase` are held at 0 and no ticks are produced.
- `a_int`=1 with `a_frac`=0 gives `tick` every cycle.
- `en`=0:
  - synchronous clear of `cnt`, `acc`, `phase`;
  - `tick` and `bit_tick` forced low;
  - the shadow configuration is applied immediately if pending.
- `cfg_load`:
  - shadow ← inputs and `cfg_pending` ← 1.
  - A second load before apply overwrites the shadow. Only one `cfg_ack` is produced.
- Apply happens when `cfg_pending` and one of: `en`=0, `a_int`=0, or the current interval ends (`cnt`=P-1).
- On apply:
  - active ← shadow;
  - `cnt`, `acc`, `phase` ← 0;
  - `cfg_pending` ← 0;
  - `cfg_ack` is pulsed next cycle.
  - The `tick` of the ending interval is still emitted.
- `cfg_load` coinciding with an apply cycle: the new shadow is captured and `cfg_pending` stays 1. The apply uses the old shadow.
- `rst` mid-operation:
  - all state returns to reset values in the same cycle (async);
  - the shadow is cleared and `cfg_pending` ← 0.

## Timing
- Reset values: `tick`, `bit_tick`, `cfg_ack`, `cfg_pending` = 0; `phase` = 0.
- With `en` high and `cnt`=0 in cycle 0, the first `tick` is in cycle P1, then every P thereafter. Periods average exactly `a_int` + `a_frac`/2^FRAC_W.
- `cfg_pending` rises in the cycle after `cfg_load`.
- Worst-case apply latency is one full interval plus 1 cycle.
- `cfg_ack` is 1 cycle after the apply decision.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `BAUD_GEN_FRAC_EN` defined: fractional accumulator present; behaviour as above.
- `BAUD_GEN_FRAC_EN` undefined:
  - `acc` is not instantiated;
  - `div_frac` is still a port but is ignored;
  - P = `a_int` exactly.

## Structure
- Shared package `uart_pkg`:
  - `OSR16`/`OSR8` encoding constants;
  - the `baud_cfg_t` struct {int, frac, osr};
  - default widths, `DIV_RST`.
- One natural sub-module, `baud_frac_acc`: the accumulator plus carry → interval-length logic. It is wrapped by `BAUD_GEN_FRAC_EN`.
- Counter, phase, shadow and apply logic stay in the top module.

## Test plan
- Reset, then `en`=1 with default config → first `tick` at cycle 15, then every 15 cycles. `bit_tick` on every 16th `tick` (cycle 240).
- `div_int`=5, `div_frac`=8, load, `en`=1 → ticks at cycles 5, 11, 16, 22 (periods 5, 6, 5, 6).
- `osr_sel`=1, `div_int`=4 → `bit_tick` every 32 cycles; `phase` cycles 0..7.
- Load 20 mid-interval while `a_int`=10 → `cfg_pending` high. Apply at the interval end, `cfg_ack` 1 cycle later, next tick 20 cycles after apply. Two back-to-back loads → single ack carrying the second value.
- `div_int`=0 applied → no ticks for 100 cycles. Load 3 → apply without waiting for a boundary; ticks every 3 cycles.
- `rst` asserted mid-interval with load pending → outputs 0 immediately; `cfg_pending`=0; default divisor restored.
